edit_ctrl_fsm: RTL and testbench

Parametrised edit-mode controller for the clock/date/timer display.
- Selects which display unit is being edited from NUM_MODES mode switches.
- Moves an edit cursor over NUM_POS fields with wrap-around.
- Turns debounced up/down buttons into single-cycle inc/dec pulses, with hold-to-auto-repeat.
- Sits between the debounced switch/button inputs and the time/date/timer register banks and display mux.

---
 rtl/edit_ctrl_if.sv | 30 +++
 rtl/edit_ctrl_fsm.sv | 163 ++++++++++++++++
 tb/tb_edit_ctrl_fsm.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/edit_ctrl_if.sv
// Edit controller bus: debounced switch/button inputs and
// edit-state outputs toward register banks and display mux.
interface edit_ctrl_if #(
  parameter int NUM_MODES = 3,
  parameter int NUM_POS   = 3
);
  localparam int MODE_W = $clog2(NUM_MODES + 1);
  localparam int POS_W  = (NUM_POS > 2) ? $clog2(NUM_POS) : 1;

  logic [NUM_MODES-1:0] sw;
  logic [3:0]           btn;
  logic                 editing;
  logic [MODE_W-1:0]    edit_mode;
  logic [POS_W-1:0]     cursor;
  logic [NUM_POS-1:0]   field_sel;
  logic                 inc_pulse;
  logic                 dec_pulse;

  modport master (
    output sw, btn,
    input  editing, edit_mode, cursor,
    input  field_sel, inc_pulse, dec_pulse
  );

  modport slave (
    input  sw, btn,
    output editing, edit_mode, cursor,
    output field_sel, inc_pulse, dec_pulse
  );
endinterface

// File: rtl/edit_ctrl_fsm.sv
// Edit-mode controller: mode select, wrapping cursor and
// inc/dec strobes with hold-to-auto-repeat.
module edit_ctrl_fsm #(
  parameter int NUM_MODES     = 3,
  parameter int NUM_POS       = 3,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic        clk,
  input  logic        reset,
  edit_ctrl_if.slave  bus
);
  localparam int MODE_W = $clog2(NUM_MODES + 1);
  localparam int POS_W  = (NUM_POS > 2) ? $clog2(NUM_POS) : 1;
  localparam int MAX_C  = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EDIT = 1'b1;

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(NUM_POS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HLD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_REP = CNT_W'(REPEAT_CYCLES);

  logic [0:0]         state_q, state_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [POS_W-1:0]   cursor_q, cursor_d;
  logic [NUM_POS-1:0] sel_q, sel_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic [3:0]         btn_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rep_q, rep_d;
  logic               dir_q, dir_d;

  logic [3:0]        rise;
  logic [MODE_W-1:0] pick;
  logic              up_only, dn_only;
  logic              held, fire;

  assign rise    = bus.btn & ~btn_q;
  assign up_only = bus.btn[0] & ~bus.btn[1];
  assign dn_only = bus.btn[1] & ~bus.btn[0];
  assign held    = (cnt_q != '0) &&
                   (dir_q ? dn_only : up_only);
  assign fire    = rep_q ? (cnt_q == CNT_REP)
                         : (cnt_q == CNT_HLD);

  // Highest set switch wins.
  always_comb begin
    pick = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (bus.sw[k]) pick = MODE_W'(k + 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cursor_d = cursor_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    dir_d    = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.sw) begin
          state_d  = S_EDIT;
          mode_d   = pick;
          cursor_d = POS_TOP;
        end
      end
      S_EDIT: begin
        if (~|bus.sw) begin
          state_d  = S_IDLE;
          mode_d   = '0;
          cursor_d = '0;
          cnt_d    = '0;
          rep_d    = 1'b0;
        end else begin
          if (rise[2] & ~rise[3]) begin
            cursor_d = (cursor_q == POS_TOP) ?
                       '0 : cursor_q + POS_W'(1);
          end else if (rise[3] & ~rise[2]) begin
            cursor_d = (cursor_q == '0) ?
                       POS_TOP : cursor_q - POS_W'(1);
          end
          unique case (1'b1)
            rise[0] & ~bus.btn[1]: begin
              inc_d = 1'b1;
              cnt_d = CNT_ONE;
              rep_d = 1'b0;
              dir_d = 1'b0;
            end
            rise[1] & ~bus.btn[0]: begin
              dec_d = 1'b1;
              cnt_d = CNT_ONE;
              rep_d = 1'b0;
              dir_d = 1'b1;
            end
            held: begin
              if (fire) begin
                inc_d = ~dir_q;
                dec_d = dir_q;
                cnt_d = CNT_ONE;
                rep_d = 1'b1;
              end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
            default: begin
              cnt_d = '0;
              rep_d = 1'b0;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_d = '0;
    if (state_d == S_EDIT) sel_d = NUM_POS'(1) << cursor_d;
  end

  // Button history resets high so a held button shows no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      cursor_q <= '0;
      sel_q    <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      btn_q    <= 4'b1111;
      cnt_q    <= '0;
      rep_q    <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cursor_q <= cursor_d;
      sel_q    <= sel_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      btn_q    <= bus.btn;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      dir_q    <= dir_d;
    end
  end

  assign bus.editing   = (state_q == S_EDIT);
  assign bus.edit_mode = mode_q;
  assign bus.cursor    = cursor_q;
  assign bus.field_sel = sel_q;
  assign bus.inc_pulse = inc_q;
  assign bus.dec_pulse = dec_q;
endmodule

// File: tb/tb_edit_ctrl_fsm.sv
// Directed bench for edit_ctrl_fsm with an expected-output
// queue checked one cycle after each driven step.
module tb_edit_ctrl_fsm;
  typedef struct packed {
    logic       ed;
    logic [1:0] m;
    logic [1:0] c;
    logic [2:0] sel;
    logic       i;
    logic       d;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t q[$];

  edit_ctrl_if #(.NUM_MODES(3), .NUM_POS(3)) bus ();

  edit_ctrl_fsm #(
    .NUM_MODES(3),
    .NUM_POS(3),
    .HOLD_CYCLES(4),
    .REPEAT_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic ed, input logic [1:0] m,
                              input logic [1:0] c, input logic i,
                              input logic d);
    exp_t e;
    logic [2:0] one;
    one   = 3'b001;
    e.ed  = ed;
    e.m   = m;
    e.c   = c;
    e.sel = ed ? (one << c) : 3'b000;
    e.i   = i;
    e.d   = d;
    return e;
  endfunction

  task automatic chk(input string tag);
    exp_t e;
    exp_t o;
    e = q.pop_front();
    o = {bus.editing, bus.edit_mode, bus.cursor,
         bus.field_sel, bus.inc_pulse, bus.dec_pulse};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step(input logic [2:0] s, input logic [3:0] b,
                      input logic ed, input logic [1:0] m,
                      input logic [1:0] c, input logic i,
                      input logic d, input string tag);
    bus.sw  = s;
    bus.btn = b;
    q.push_back(mk(ed, m, c, i, d));
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.sw  = 3'b000;
    bus.btn = 4'b0000;
    #12;
    q.push_back(mk(0, 0, 0, 0, 0));
    chk("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // mode entry, lock, exit
    step(3'b011, 4'b0000, 1, 2, 2, 0, 0, "enter_mode2");
    step(3'b100, 4'b0000, 1, 2, 2, 0, 0, "mode_locked");
    step(3'b000, 4'b0000, 0, 0, 0, 0, 0, "exit_idle");

    // cursor wrap
    step(3'b001, 4'b0000, 1, 1, 2, 0, 0, "enter_mode1");
    step(3'b001, 4'b0100, 1, 1, 0, 0, 0, "left_wrap");
    step(3'b001, 4'b0000, 1, 1, 0, 0, 0, "left_gap");
    step(3'b001, 4'b0100, 1, 1, 1, 0, 0, "left_1");
    step(3'b001, 4'b0000, 1, 1, 1, 0, 0, "left_gap");
    step(3'b001, 4'b0100, 1, 1, 2, 0, 0, "left_2");
    step(3'b001, 4'b0000, 1, 1, 2, 0, 0, "left_gap");
    step(3'b001, 4'b0100, 1, 1, 0, 0, 0, "left_0");
    step(3'b001, 4'b0000, 1, 1, 0, 0, 0, "left_gap");
    step(3'b001, 4'b1000, 1, 1, 2, 0, 0, "right_wrap");
    step(3'b001, 4'b0000, 1, 1, 2, 0, 0, "right_gap");
    step(3'b001, 4'b1100, 1, 1, 2, 0, 0, "left_right");
    step(3'b001, 4'b0000, 1, 1, 2, 0, 0, "lr_gap");

    // auto-repeat on up
    step(3'b001, 4'b0001, 1, 1, 2, 1, 0, "inc_first");
    for (int k = 1; k < 12; k++) begin
      step(3'b001, 4'b0001, 1, 1, 2,
           (k == 4 || k == 6 || k == 8 || k == 10), 0, "inc_repeat");
    end
    for (int k = 0; k < 4; k++) begin
      step(3'b001, 4'b0000, 1, 1, 2, 0, 0, "inc_release");
    end

    // conflict and idle
    for (int k = 0; k < 3; k++) begin
      step(3'b001, 4'b0011, 1, 1, 2, 0, 0, "both_held");
    end
    step(3'b001, 4'b0000, 1, 1, 2, 0, 0, "both_release");
    step(3'b000, 4'b0000, 0, 0, 0, 0, 0, "to_idle");
    step(3'b000, 4'b0001, 0, 0, 0, 0, 0, "idle_press");
    step(3'b000, 4'b0001, 0, 0, 0, 0, 0, "idle_hold");
    step(3'b001, 4'b0001, 1, 1, 2, 0, 0, "enter_held");
    step(3'b001, 4'b0001, 1, 1, 2, 0, 0, "held_no_edge");
    step(3'b001, 4'b0001, 1, 1, 2, 0, 0, "held_no_edge");
    step(3'b001, 4'b0000, 1, 1, 2, 0, 0, "held_release");

    // async reset mid-hold
    step(3'b001, 4'b0001, 1, 1, 2, 1, 0, "pre_rst_inc");
    step(3'b001, 4'b0001, 1, 1, 2, 0, 0, "pre_rst_hold");
    rst_n = 1'b0;
    #2;
    q.push_back(mk(0, 0, 0, 0, 0));
    chk("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b001, 4'b0001, 1, 1, 2, 0, 0, "rst_reenter");
    for (int k = 0; k < 6; k++) begin
      step(3'b001, 4'b0001, 1, 1, 2, 0, 0, "rst_held");
    end
    step(3'b001, 4'b0000, 1, 1, 2, 0, 0, "rst_release");
    step(3'b001, 4'b0001, 1, 1, 2, 1, 0, "rst_repress");
    step(3'b001, 4'b0000, 1, 1, 2, 0, 0, "rst_release2");

    // exit during down repeat
    step(3'b001, 4'b0010, 1, 1, 2, 0, 1, "dec_first");
    for (int k = 1; k < 6; k++) begin
      step(3'b001, 4'b0010, 1, 1, 2, 0, (k == 4), "dec_repeat");
    end
    step(3'b000, 4'b0010, 0, 0, 0, 0, 0, "dec_exit");
    step(3'b000, 4'b0010, 0, 0, 0, 0, 0, "dec_idle");
    step(3'b001, 4'b0010, 1, 1, 2, 0, 0, "dec_reenter");
    for (int k = 0; k < 6; k++) begin
      step(3'b001, 4'b0010, 1, 1, 2, 0, 0, "dec_held_quiet");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
